rf_write_arbiter: RTL and testbench

- Shares the single write port (WEN/RW/busW) of the 8x8 register_file between two independent writers: requester A (ALU writeback) and requester B (load/external writeback).
- Each requester pushes (address, data) beats through a valid/ready handshake into its own small FIFO.
- A round-robin arbiter pops one beat per cycle and drives registered write-port signals straight into register_file.
- Register 0 is hardwired zero, so writes to it are filtered here.

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_write_arbiter_wr_fifo.sv | 54 +++++
 rtl/rf_write_arbiter.sv | 113 +++++++++++
 tb/tb_rf_write_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the default widths, the hardwired-zero register index and the requester encoding.
package rf_arb_pkg;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 1 << AW;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;
endpackage

// File: rtl/rf_write_arbiter_wr_fifo.sv
// Small per-requester beat FIFO.
// ready is derived from the registered count only, so a full FIFO never accepts a beat, even while it is popping.
module wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 11
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         nonempty,
    output logic         ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign ready     = (count_q < (PW+1)'(DEPTH));
    assign nonempty  = (count_q != '0);
    assign do_push   = push && ready;
    assign do_pop    = pop && nonempty;
    assign head_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register_file write port between two buffered writers.
// Beats addressed to register 0 are consumed without a write and flagged on zero_drop.
module rf_write_arbiter #(
    parameter int DW    = rf_arb_pkg::DW,
    parameter int AW    = rf_arb_pkg::AW,
    parameter int DEPTH = 2
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          WEN,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          zero_drop,
    output logic          idle
);
    import rf_arb_pkg::*;

    localparam int BW = AW + DW;

    logic [BW-1:0] a_head, b_head, sel_head;
    logic          a_nonempty, b_nonempty;
    logic          pop_a, pop_b, pop_any, hit_zero;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    req_e          rr_q, rr_d;
    logic          wen_q, wen_d;
    logic          zdrop_q, zdrop_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;

    wr_fifo #(.DEPTH(DEPTH), .W(BW)) u_fifo_a (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (a_valid),
        .push_data ({a_addr, a_data}),
        .pop       (pop_a),
        .head_data (a_head),
        .nonempty  (a_nonempty),
        .ready     (a_ready)
    );

    wr_fifo #(.DEPTH(DEPTH), .W(BW)) u_fifo_b (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (b_valid),
        .push_data ({b_addr, b_data}),
        .pop       (pop_b),
        .head_data (b_head),
        .nonempty  (b_nonempty),
        .ready     (b_ready)
    );

    // rr_q only decides ties; any pop hands priority to the requester not served.
    always_comb begin
        pop_a = 1'b0;
        pop_b = 1'b0;
        rr_d  = rr_q;
        if (a_nonempty && b_nonempty) begin
            if (rr_q == REQ_A) pop_a = 1'b1;
            else               pop_b = 1'b1;
        end else if (a_nonempty) begin
            pop_a = 1'b1;
        end else if (b_nonempty) begin
            pop_b = 1'b1;
        end
        if (pop_a)      rr_d = REQ_B;
        else if (pop_b) rr_d = REQ_A;
    end

    assign pop_any   = pop_a || pop_b;
    assign sel_head  = pop_b ? b_head : a_head;
    assign head_addr = sel_head[BW-1:DW];
    assign head_data = sel_head[DW-1:0];
    assign hit_zero  = (head_addr == AW'(ZERO_REG));

    always_comb begin
        wen_d   = pop_any && !hit_zero;
        zdrop_d = pop_any && hit_zero;
        rw_d    = wen_d ? head_addr : rw_q;
        busw_d  = wen_d ? head_data : busw_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_q    <= REQ_A;
            wen_q   <= 1'b0;
            zdrop_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            zdrop_q <= zdrop_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    assign WEN       = wen_q;
    assign RW        = rw_q;
    assign busW      = busw_q;
    assign zero_drop = zdrop_q;
    assign idle      = !a_nonempty && !b_nonempty && !wen_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised bench for rf_write_arbiter against a queue-based model of the write-port sharing rules.
// A behavioural register file is attached to the write port so that the values written can be read back.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int TDW    = 8;
    localparam int TAW    = 3;
    localparam int TDEPTH = 2;

    logic           Clk = 1'b0;
    logic           Rst_n;
    logic           a_valid, b_valid;
    logic           a_ready, b_ready;
    logic [TAW-1:0] a_addr, b_addr;
    logic [TDW-1:0] a_data, b_data;
    logic           WEN, zero_drop, idle;
    logic [TAW-1:0] RW;
    logic [TDW-1:0] busW;

    rf_write_arbiter #(.DW(TDW), .AW(TAW), .DEPTH(TDEPTH)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .WEN       (WEN),
        .RW        (RW),
        .busW      (busW),
        .zero_drop (zero_drop),
        .idle      (idle)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: one queue per requester, a tie-break flag, and the expected outputs.
    logic [TAW+TDW-1:0] qa[$];
    logic [TAW+TDW-1:0] qb[$];
    bit                 rr_a;
    bit                 exp_wen, exp_zd;
    logic [TAW-1:0]     exp_rw;
    logic [TDW-1:0]     exp_busw;
    logic [TDW-1:0]     mdl_rf [NREG];
    logic [TDW-1:0]     obs_rf [NREG];

    always @(posedge Clk) begin
        if (WEN) obs_rf[RW] <= busW;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        rr_a     = 1'b1;
        exp_wen  = 1'b0;
        exp_zd   = 1'b0;
        exp_rw   = '0;
        exp_busw = '0;
    endtask

    // Called just after a falling edge: drive one cycle of inputs, advance the model, check after the next rising edge.
    task automatic cycle(input bit va, input logic [TAW-1:0] aa, input logic [TDW-1:0] da,
                         input bit vb, input logic [TAW-1:0] ab, input logic [TDW-1:0] db);
        bit                 acc_a, acc_b;
        int                 who;
        logic [TAW+TDW-1:0] beat;
        a_valid = va; a_addr = aa; a_data = da;
        b_valid = vb; b_addr = ab; b_data = db;
        chk("a_ready", a_ready, qa.size() < TDEPTH);
        chk("b_ready", b_ready, qb.size() < TDEPTH);
        if (exp_wen) mdl_rf[exp_rw] = exp_busw;
        acc_a = va && (qa.size() < TDEPTH);
        acc_b = vb && (qb.size() < TDEPTH);
        who = -1;
        if (qa.size() > 0 && qb.size() > 0) who = rr_a ? 0 : 1;
        else if (qa.size() > 0)             who = 0;
        else if (qb.size() > 0)             who = 1;
        beat = '0;
        if (who == 0) begin beat = qa.pop_front(); rr_a = 1'b0; end
        if (who == 1) begin beat = qb.pop_front(); rr_a = 1'b1; end
        exp_wen = 1'b0;
        exp_zd  = 1'b0;
        if (who >= 0) begin
            if (beat[TAW+TDW-1:TDW] != 0) begin
                exp_wen  = 1'b1;
                exp_rw   = beat[TAW+TDW-1:TDW];
                exp_busw = beat[TDW-1:0];
            end else begin
                exp_zd = 1'b1;
            end
        end
        if (acc_a) qa.push_back({aa, da});
        if (acc_b) qb.push_back({ab, db});
        @(posedge Clk);
        @(negedge Clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("WEN", WEN, exp_wen);
        chk("RW", RW, exp_rw);
        chk("busW", busW, exp_busw);
        chk("zero_drop", zero_drop, exp_zd);
        chk("idle", idle, qa.size() == 0 && qb.size() == 0 && !exp_wen);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic reset_midsim();
        Rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("rst_WEN", WEN, 0);
        chk("rst_RW", RW, 0);
        chk("rst_busW", busW, 0);
        chk("rst_zero_drop", zero_drop, 0);
        chk("rst_idle", idle, 1);
        model_clear();
        @(negedge Clk);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        Rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            obs_rf[i] = '0;
            mdl_rf[i] = '0;
        end
        Rst_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        model_clear();
        #1;
        chk("init_WEN", WEN, 0);
        chk("init_idle", idle, 1);
        chk("init_a_ready", a_ready, 1);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single write from A, then readback from the attached register file.
        cycle(1'b1, 3'd1, 8'b10101010, 1'b0, '0, '0);
        idle_cycles(3);
        chk("rf1_readback", obs_rf[1], 8'b10101010);

        // Contention with priority back on A.
        reset_midsim();
        cycle(1'b1, 3'd2, 8'h11, 1'b1, 3'd3, 8'h22);
        cycle(1'b1, 3'd4, 8'h33, 1'b1, 3'd5, 8'h44);
        idle_cycles(5);
        chk("rf4_readback", obs_rf[4], 8'h33);

        // Backpressure: both requesters hold valid with incrementing data.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 3'(i % 7 + 1), 8'(8'h50 + i), 1'b1, 3'(7 - i % 7), 8'(8'hA0 + i));
        idle_cycles(6);

        // Register 0 filter.
        cycle(1'b1, 3'd0, 8'b11001100, 1'b0, '0, '0);
        cycle(1'b1, 3'd7, 8'b11111111, 1'b0, '0, '0);
        idle_cycles(5);
        chk("rf0_zero", obs_rf[0], 8'h00);
        chk("rf7_readback", obs_rf[7], 8'hFF);

        // Idle hold, then a simultaneous push served according to the carried priority.
        cycle(1'b1, 3'd6, 8'h5A, 1'b1, 3'd6, 8'hA5);
        idle_cycles(4);

        // Randomised traffic with bursts and quiet periods.
        for (int i = 0; i < 3000; i++) begin
            int pa, pb;
            pa = ((i / 200) % 3 == 2) ? 15 : 70;
            pb = ((i / 300) % 2 == 1) ? 90 : 50;
            cycle($urandom_range(99) < pa, 3'($urandom_range(7)), 8'($urandom),
                  $urandom_range(99) < pb, 3'($urandom_range(7)), 8'($urandom));
        end

        // Reset with beats still queued: none of them may appear afterwards.
        cycle(1'b1, 3'd3, 8'hE1, 1'b1, 3'd5, 8'hE2);
        cycle(1'b1, 3'd4, 8'hE3, 1'b1, 3'd6, 8'hE4);
        reset_midsim();
        idle_cycles(5);

        for (int i = 0; i < NREG; i++)
            chk($sformatf("rf_final[%0d]", i), obs_rf[i], mdl_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
